// File: rtl/operand_issue_pkg.sv
// Shared types and constants for the operand-fetch / issue stage.
package operand_issue_pkg;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 1 << AW;

  typedef logic [DW-1:0] data_t;
  typedef logic [AW-1:0] addr_t;

  localparam addr_t REG_ZERO = '0;

  typedef struct packed {
    data_t a;
    data_t b;
    addr_t rd;
    logic  wr;
  } issue_t;

  // r0 reads as zero; a same-cycle writeback to the source wins over the register file
  function automatic data_t read_operand(addr_t r, data_t rf, logic wb_valid,
                                         addr_t wb_addr, data_t wb_data);
    if (r == REG_ZERO) return '0;
    if (wb_valid && (wb_addr == r)) return wb_data;
    return rf;
  endfunction

endpackage

// File: rtl/operand_issue_if.sv
// Decode-in, execute-out, register-file and writeback signals of the issue stage.
interface operand_issue_if;
  import operand_issue_pkg::*;

  logic  in_valid;
  logic  in_ready;
  addr_t in_rs;
  addr_t in_rt;
  addr_t in_rd;
  logic  in_use_rs;
  logic  in_use_rt;
  logic  in_wr;

  logic  out_valid;
  logic  out_ready;
  data_t out_a;
  data_t out_b;
  addr_t out_rd;
  logic  out_wr;

  addr_t rf_addr_a;
  addr_t rf_addr_b;
  data_t rf_data_a;
  data_t rf_data_b;
  logic  rf_we;
  addr_t rf_waddr;
  data_t rf_wdata;

  logic  wb_valid;
  addr_t wb_addr;
  data_t wb_data;

  modport master (
    input  in_valid, in_rs, in_rt, in_rd, in_use_rs, in_use_rt, in_wr,
    output in_ready,
    output out_valid, out_a, out_b, out_rd, out_wr,
    input  out_ready,
    output rf_addr_a, rf_addr_b, rf_we, rf_waddr, rf_wdata,
    input  rf_data_a, rf_data_b,
    input  wb_valid, wb_addr, wb_data
  );

  modport slave (
    output in_valid, in_rs, in_rt, in_rd, in_use_rs, in_use_rt, in_wr,
    input  in_ready,
    input  out_valid, out_a, out_b, out_rd, out_wr,
    output out_ready,
    input  rf_addr_a, rf_addr_b, rf_we, rf_waddr, rf_wdata,
    output rf_data_a, rf_data_b,
    output wb_valid, wb_addr, wb_data
  );

endinterface

// File: rtl/operand_issue_reg_scoreboard.sv
// Busy-bit scoreboard of pending destination writes; set beats clear, lookups see same-cycle clears.
module operand_issue_reg_scoreboard
  import operand_issue_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  set_en,
  input  addr_t set_addr,
  input  logic  clr_en,
  input  addr_t clr_addr,
  input  addr_t look_a,
  input  addr_t look_b,
  input  addr_t look_c,
  output logic  pend_a_c,
  output logic  pend_b_c,
  output logic  pend_c_c
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nx;

  always_comb begin
    busy_nx = busy;
    if (clr_en) busy_nx[clr_addr] = 1'b0;
    if (set_en) busy_nx[set_addr] = 1'b1;
    busy_nx[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nx;
  end

  // A register being written back this cycle is no longer pending for readers
  assign pend_a_c = busy[look_a] && !(clr_en && (clr_addr == look_a));
  assign pend_b_c = busy[look_b] && !(clr_en && (clr_addr == look_b));
  assign pend_c_c = busy[look_c] && !(clr_en && (clr_addr == look_c));

endmodule

// File: rtl/operand_issue.sv
// Operand fetch and issue: hazard stall, writeback bypass, issue register and stall counter.
module operand_issue
  import operand_issue_pkg::*;
#(
  parameter int unsigned CW = 16
) (
  input  logic           clk,
  input  logic           rst,
  operand_issue_if.master bus,
  output logic [CW-1:0]  stall_cnt
);

  localparam logic [CW-1:0] STALL_MAX = '1;

  logic   wb_clr_c;
  logic   set_c;
  logic   pend_rs_c;
  logic   pend_rt_c;
  logic   pend_rd_c;
  logic   hazard_c;
  logic   ready_c;
  logic   accept_c;
  logic   out_valid_q;
  issue_t bundle_q;
  issue_t bundle_d;

  assign wb_clr_c = bus.wb_valid && (bus.wb_addr != REG_ZERO);
  assign set_c    = accept_c && bus.in_wr && (bus.in_rd != REG_ZERO);

  operand_issue_reg_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (set_c),
    .set_addr (bus.in_rd),
    .clr_en   (wb_clr_c),
    .clr_addr (bus.wb_addr),
    .look_a   (bus.in_rs),
    .look_b   (bus.in_rt),
    .look_c   (bus.in_rd),
    .pend_a_c (pend_rs_c),
    .pend_b_c (pend_rt_c),
    .pend_c_c (pend_rd_c)
  );

  // RAW on either used source, WAW on the destination
  assign hazard_c = bus.in_valid && ((bus.in_use_rs && pend_rs_c) ||
                                     (bus.in_use_rt && pend_rt_c) ||
                                     (bus.in_wr     && pend_rd_c));
  assign ready_c  = (!out_valid_q || bus.out_ready) && !hazard_c;
  assign accept_c = bus.in_valid && ready_c;
  assign bus.in_ready = ready_c;

  assign bus.rf_addr_a = bus.in_rs;
  assign bus.rf_addr_b = bus.in_rt;
  assign bus.rf_we     = wb_clr_c;
  assign bus.rf_waddr  = bus.wb_addr;
  assign bus.rf_wdata  = bus.wb_data;

  always_comb begin
    bundle_d.a  = read_operand(bus.in_rs, bus.rf_data_a, bus.wb_valid, bus.wb_addr, bus.wb_data);
    bundle_d.b  = read_operand(bus.in_rt, bus.rf_data_b, bus.wb_valid, bus.wb_addr, bus.wb_data);
    bundle_d.rd = bus.in_rd;
    bundle_d.wr = bus.in_wr && (bus.in_rd != REG_ZERO);
  end

  // Bundle fields only change on accept, so they stay stable under back-pressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else if (accept_c) begin
      out_valid_q <= 1'b1;
      bundle_q    <= bundle_d;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else if (hazard_c && (stall_cnt != STALL_MAX)) stall_cnt <= stall_cnt + CW'(1);
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_a     = bundle_q.a;
  assign bus.out_b     = bundle_q.b;
  assign bus.out_rd    = bundle_q.rd;
  assign bus.out_wr    = bundle_q.wr;

endmodule

// File: tb/tb_operand_issue.sv
// Randomized and directed bench for operand_issue against a behavioural issue-stage model.
`timescale 1ns/1ps
module tb_operand_issue;
  import operand_issue_pkg::*;

  localparam int unsigned TB_CW     = 4;
  localparam int unsigned STALL_MAX = (1 << TB_CW) - 1;
  localparam int unsigned VW        = 2 + 2 * DW + AW + TB_CW;

  logic             clk = 1'b0;
  logic             rst;
  logic [TB_CW-1:0] stall_cnt;
  int               n_checks = 0;
  int               n_fail   = 0;

  operand_issue_if bus ();

  operand_issue #(.CW(TB_CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // Register file seen by the DUT; only the DUT's write port updates it
  data_t rf_mem [NREG];
  assign bus.rf_data_a = rf_mem[bus.rf_addr_a];
  assign bus.rf_data_b = rf_mem[bus.rf_addr_b];
  always @(posedge clk) if (bus.rf_we) rf_mem[bus.rf_waddr] <= bus.rf_wdata;

  // Behavioural model state
  bit          m_busy [NREG];
  data_t       m_mem  [NREG];
  logic        m_valid;
  data_t       m_a, m_b;
  addr_t       m_rd;
  logic        m_wr;
  int unsigned m_stall;
  logic        m_hz;
  logic        exp_ready;

  function automatic bit m_pending(addr_t r);
    return m_busy[r] && !(bus.wb_valid && bus.wb_addr == r && r != 0);
  endfunction

  function automatic data_t m_operand(addr_t r);
    if (r == 0) return '0;
    if (bus.wb_valid && bus.wb_addr == r) return bus.wb_data;
    return m_mem[r];
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_valid, m_a, m_b, m_rd, m_wr, TB_CW'(m_stall)};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {bus.out_valid, bus.out_a, bus.out_b, bus.out_rd, bus.out_wr, stall_cnt};
  endfunction

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_valid = 1'b0; m_a = '0; m_b = '0; m_rd = '0; m_wr = 1'b0; m_stall = 0;
  endtask

  task automatic model_pre();
    m_hz = bus.in_valid && ((bus.in_use_rs && m_pending(bus.in_rs)) ||
                            (bus.in_use_rt && m_pending(bus.in_rt)) ||
                            (bus.in_wr     && m_pending(bus.in_rd)));
    exp_ready = (!m_valid || bus.out_ready) && !m_hz;
  endtask

  task automatic model_post();
    bit acc;
    acc = bus.in_valid && exp_ready;
    if (acc) begin
      m_a = m_operand(bus.in_rs); m_b = m_operand(bus.in_rt);
      m_rd = bus.in_rd; m_wr = bus.in_wr && bus.in_rd != 0; m_valid = 1'b1;
    end else if (bus.out_ready) m_valid = 1'b0;
    if (bus.wb_valid && bus.wb_addr != 0) begin
      m_busy[bus.wb_addr] = 1'b0;
      m_mem[bus.wb_addr]  = bus.wb_data;
    end
    if (acc && bus.in_wr && bus.in_rd != 0) m_busy[bus.in_rd] = 1'b1;
    if (m_hz && m_stall < STALL_MAX) m_stall++;
  endtask

  task automatic step_pre();  #1; model_pre(); endtask
  task automatic step_post(); @(posedge clk); model_post(); #1; endtask
  task automatic tick();      step_pre(); step_post(); endtask

  task automatic instr(input logic v, input int rs, input int rt, input int rd,
                       input logic urs, input logic urt, input logic wr);
    bus.in_valid = v; bus.in_rs = addr_t'(rs); bus.in_rt = addr_t'(rt); bus.in_rd = addr_t'(rd);
    bus.in_use_rs = urs; bus.in_use_rt = urt; bus.in_wr = wr;
  endtask

  task automatic wb(input logic v, input int a, input data_t d);
    bus.wb_valid = v; bus.wb_addr = addr_t'(a); bus.wb_data = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr(0, 0, 0, 0, 0, 0, 0); wb(0, 0, '0); bus.out_ready = 1'b1;
    #1;
    n_checks++; if (dut_vec() !== {VW{1'b0}}) begin n_fail++; $display("FAIL reset.outputs: got %h want 0", dut_vec()); end
    @(posedge clk); #1; rst = 1'b0; model_reset();
  endtask

  task automatic test_preload();
    for (int r = 1; r < int'(NREG); r++) begin
      wb(1, r, $urandom()); step_pre();
      n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== addr_t'(r) || bus.rf_wdata !== bus.wb_data) begin
        n_fail++; $display("FAIL preload.rf_write r%0d: got we=%b addr=%0d want we=1 addr=%0d", r, bus.rf_we, bus.rf_waddr, r); end
      step_post();
    end
    wb(0, 0, '0);
  endtask

  task automatic test_basic();
    wb(1, 1, 32'd5); tick(); wb(1, 2, 32'd7); tick(); wb(0, 0, '0);
    instr(1, 1, 2, 0, 1, 1, 0); step_pre();
    n_checks++; if (bus.rf_addr_a !== 5'd1 || bus.rf_addr_b !== 5'd2) begin n_fail++; $display("FAIL basic.rf_addr: got %0d/%0d want 1/2", bus.rf_addr_a, bus.rf_addr_b); end
    step_post();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_a !== 32'd5 || bus.out_b !== 32'd7 || stall_cnt !== '0) begin
      n_fail++; $display("FAIL basic.issue: got v=%b a=%0d b=%0d stall=%0d want v=1 a=5 b=7 stall=0", bus.out_valid, bus.out_a, bus.out_b, stall_cnt); end
    instr(0, 0, 0, 0, 0, 0, 0); tick();
  endtask

  task automatic test_raw_bypass();
    instr(1, 0, 0, 3, 0, 0, 1); tick();
    instr(1, 3, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step_pre();
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL raw.stall cyc%0d: in_ready got %b want 0", i, bus.in_ready); end
      step_post();
      n_checks++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL raw.hold cyc%0d: got %h want %h", i, dut_vec(), exp_vec()); end
    end
    wb(1, 3, 32'h1234); step_pre();
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL raw.bypass_ready: got %b want 1", bus.in_ready); end
    step_post();
    n_checks++; if (bus.out_a !== 32'h1234 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL raw.bypass_data: got a=%h v=%b want a=1234 v=1", bus.out_a, bus.out_valid); end
    n_checks++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL raw.bundle: got %h want %h", dut_vec(), exp_vec()); end
    wb(0, 0, '0); instr(0, 0, 0, 0, 0, 0, 0); tick();
  endtask

  task automatic test_zero_reg();
    instr(1, 0, 0, 0, 1, 1, 1); tick();
    n_checks++; if (bus.out_a !== '0 || bus.out_b !== '0 || bus.out_wr !== 1'b0 || bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL zero.bundle: got a=%h b=%h wr=%b v=%b want 0/0/0/1", bus.out_a, bus.out_b, bus.out_wr, bus.out_valid); end
    step_pre();
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL zero.no_busy: in_ready got %b want 1", bus.in_ready); end
    step_post();
    instr(0, 0, 0, 0, 0, 0, 0); wb(1, 0, 32'hdead_beef); step_pre();
    n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL zero.rf_we: got %b want 0", bus.rf_we); end
    step_post(); wb(0, 0, '0);
  endtask

  task automatic test_backpressure();
    logic [VW-1:0] held;
    instr(0, 0, 0, 0, 0, 0, 0); tick();
    bus.out_ready = 1'b0; instr(1, 5, 6, 0, 1, 1, 0); tick();
    held = dut_vec();
    instr(1, 7, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step_pre();
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp.in_ready cyc%0d: got %b want 0", i, bus.in_ready); end
      step_post();
      n_checks++; if (dut_vec() !== exp_vec() || dut_vec() !== held) begin n_fail++; $display("FAIL bp.hold cyc%0d: got %h want %h", i, dut_vec(), exp_vec()); end
    end
    bus.out_ready = 1'b1; step_pre();
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp.release_ready: got %b want 1", bus.in_ready); end
    step_post();
    n_checks++; if (dut_vec() !== exp_vec() || bus.out_a !== m_mem[7]) begin n_fail++; $display("FAIL bp.next_bundle: got %h want %h", dut_vec(), exp_vec()); end
    instr(0, 0, 0, 0, 0, 0, 0); tick();
  endtask

  task automatic test_set_wins();
    instr(1, 0, 0, 4, 0, 0, 1); tick();
    wb(1, 4, 32'h44); step_pre();
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL setwins.waw_clear: in_ready got %b want 1", bus.in_ready); end
    step_post();
    wb(0, 0, '0); instr(1, 4, 0, 0, 1, 0, 0); step_pre();
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL setwins.still_busy: in_ready got %b want 0", bus.in_ready); end
    step_post();
    wb(1, 4, 32'h4444); tick();
    n_checks++; if (dut_vec() !== exp_vec() || bus.out_a !== 32'h4444) begin n_fail++; $display("FAIL setwins.release: got %h want %h", dut_vec(), exp_vec()); end
    wb(0, 0, '0); instr(0, 0, 0, 0, 0, 0, 0); tick();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0; instr(1, 0, 0, 3, 0, 0, 1); tick();
    instr(0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1; #1;
    n_checks++; if (bus.out_valid !== 1'b0 || stall_cnt !== '0) begin n_fail++; $display("FAIL rstmid.async: got v=%b stall=%0d want 0/0", bus.out_valid, stall_cnt); end
    model_reset();
    @(posedge clk); #1; rst = 1'b0;
    bus.out_ready = 1'b1; instr(1, 3, 0, 0, 1, 0, 0); step_pre();
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid.busy_cleared: in_ready got %b want 1", bus.in_ready); end
    step_post();
    n_checks++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL rstmid.issue: got %h want %h", dut_vec(), exp_vec()); end
    instr(0, 0, 0, 0, 0, 0, 0); tick();
  endtask

  task automatic test_saturation();
    instr(1, 0, 0, 9, 0, 0, 1); tick();
    instr(1, 0, 9, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) tick();
    n_checks++; if (stall_cnt !== TB_CW'(STALL_MAX) || dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL sat.stall_cnt: got %0d want %0d", stall_cnt, STALL_MAX); end
    wb(1, 9, 32'h99); tick(); wb(0, 0, '0); instr(0, 0, 0, 0, 0, 0, 0); tick();
    n_checks++; if (stall_cnt !== TB_CW'(STALL_MAX)) begin n_fail++; $display("FAIL sat.hold: got %0d want %0d", stall_cnt, STALL_MAX); end
  endtask

  task automatic test_random();
    int busy_list[$];
    instr(0, 0, 0, 0, 0, 0, 0); exp_ready = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if (!(bus.in_valid && !exp_ready))
        instr($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      bus.out_ready = $urandom_range(0, 3) != 0;
      busy_list.delete();
      for (int r = 1; r < 8; r++) if (m_busy[r]) busy_list.push_back(r);
      if (busy_list.size() > 0 && $urandom_range(0, 1) == 1)
        wb(1, busy_list[$urandom_range(0, busy_list.size() - 1)], $urandom());
      else
        wb($urandom_range(0, 3) == 0, $urandom_range(0, 7), $urandom());
      step_pre();
      n_checks++; if (bus.in_ready !== exp_ready || bus.rf_we !== (bus.wb_valid && bus.wb_addr != 0)) begin
        n_fail++; $display("FAIL rand.ready cyc%0d: got rdy=%b we=%b want rdy=%b", c, bus.in_ready, bus.rf_we, exp_ready); end
      step_post();
      n_checks++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL rand.bundle cyc%0d: got %h want %h", c, dut_vec(), exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_basic();
    test_raw_bypass();
    test_zero_reg();
    test_backpressure();
    test_set_wins();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
